// File: rtl/tracklet_seq_pkg.sv
// Shared state encoding and default parameters for the tracklet processing sequencer.
package tracklet_seq_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_BX_W    = 3;
  localparam int DEF_RST_CYC = 3;
  localparam int DEF_PRE_CYC = 2;
  localparam int DEF_STAGGER = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_WAIT = 2'd2,
    S_RUN  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tracklet_proc_sequencer.sv
// Sequences a downstream processing chain: reset pulse, settle gap, then per-period
// staggered channel enables with a bunch-crossing index, ending on stop or a period limit.
module tracklet_proc_sequencer
  import tracklet_seq_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BX_W    = DEF_BX_W,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int STAGGER = DEF_STAGGER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [BX_W-1:0]  num_bx,
  input  logic [N_CH-1:0]  ch_mask,
  output logic             proc_rst,
  output logic [N_CH-1:0]  en_proc,
  output logic [BX_W-1:0]  bx_cnt,
  output logic             busy,
  output logic             done
);

  localparam int CYC_MAX = (RST_CYC > PRE_CYC) ? RST_CYC : PRE_CYC;
  localparam int CYC_W   = (CYC_MAX < 1) ? 1 : $clog2(CYC_MAX + 1);

  seq_state_t       state, state_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;
  logic [CNT_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] p_last, p_last_nxt;
  logic [BX_W-1:0]  bx, bx_nxt;
  logic [BX_W-1:0]  nbx, nbx_nxt;
  logic [N_CH-1:0]  mask, mask_nxt;
  logic             pend, pend_nxt;
  logic             done_nxt;
  logic             last_bx;
  logic [N_CH-1:0]  fire;

  assign last_bx = (nbx != '0) && (bx == nbx - 1'b1);

  always_comb begin
    state_nxt  = state;
    cyc_nxt    = cyc;
    phase_nxt  = phase;
    p_last_nxt = p_last;
    bx_nxt     = bx;
    nbx_nxt    = nbx;
    mask_nxt   = mask;
    pend_nxt   = pend;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_RST;
          cyc_nxt    = CYC_W'(RST_CYC - 1);
          // A period below 2 cannot hold distinct first and last phases.
          p_last_nxt = (period < CNT_W'(2)) ? CNT_W'(1) : period - 1'b1;
          nbx_nxt    = num_bx;
          mask_nxt   = ch_mask;
          phase_nxt  = '0;
          bx_nxt     = '0;
          pend_nxt   = 1'b0;
        end
      end
      S_RST: begin
        if (cyc == '0) begin
          if (PRE_CYC > 0) begin
            state_nxt = S_WAIT;
            cyc_nxt   = CYC_W'(PRE_CYC - 1);
          end else begin
            state_nxt = S_RUN;
          end
        end else begin
          cyc_nxt = cyc - 1'b1;
        end
      end
      S_WAIT: begin
        if (cyc == '0) state_nxt = S_RUN;
        else           cyc_nxt   = cyc - 1'b1;
      end
      S_RUN: begin
        if (stop) pend_nxt = 1'b1;
        if (phase == p_last) begin
          phase_nxt = '0;
          // A stop arriving on the last phase ends the run in the same cycle.
          if (stop || pend || last_bx) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            pend_nxt  = 1'b0;
          end else begin
            bx_nxt = bx + 1'b1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Channel offsets at or beyond the period never match a phase below the period.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int OFF = k * STAGGER;
    assign fire[k] = (state == S_RUN) && mask[k] && (32'(phase) == 32'(OFF));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cyc      <= '0;
      phase    <= '0;
      p_last   <= '0;
      bx       <= '0;
      nbx      <= '0;
      mask     <= '0;
      pend     <= 1'b0;
      proc_rst <= 1'b0;
      en_proc  <= '0;
      bx_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      phase    <= phase_nxt;
      p_last   <= p_last_nxt;
      bx       <= bx_nxt;
      nbx      <= nbx_nxt;
      mask     <= mask_nxt;
      pend     <= pend_nxt;
      proc_rst <= (state == S_RST);
      en_proc  <= fire;
      bx_cnt   <= bx;
      busy     <= (state != S_IDLE);
      done     <= done_nxt;
    end
  end

endmodule
